// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory slave for the RV32I core's data port. It accepts a load or store
// request, waits a programmable number of cycles, then completes the
// transaction with a one-cycle data_ready pulse. The design is backed by an
// on-chip word array, and it also serves as the memory model in benches.
//
// Parameters
//   ADDR_WIDTH   word-address bits; capacity is 2**ADDR_WIDTH 32-bit words (<= 29)
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//   WAIT_CYCLES  extra cycles between accept and data_ready (0..15)
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   data_rd_en_ma    load request, held by the core until data_ready
//   data_wr_en_ma    store request, held by the core until data_ready
//   data_addr        byte address; bits [1:0] are ignored (word access)
//   data_wr          store data, already lane-aligned by the core
//   data_rd_en_ctrl  byte-lane strobe; bit i enables data_wr[8i+7:8i]
//   data_ready       one-cycle completion pulse
//   data_rd          load data; valid only while data_ready=1, otherwise 0
//   access_err       one-cycle error flag, coincident with data_ready
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_rd_en_ma,
  input  logic        data_wr_en_ma,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_rd_en_ctrl,
  output logic        data_ready,
  output logic [31:0] data_rd,
  output logic        access_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        rd_q;
  logic        wr_q;

  logic [31:0] mem [DEPTH];

  // Effective transaction fields. When WAIT_CYCLES=0 the response is formed on
  // the accept edge itself, before the latched copy exists, so the live inputs
  // are used in IDLE and the latched copy everywhere else.
  logic        in_idle;
  logic        req;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [3:0]  eff_strb;
  logic        eff_rd;
  logic        eff_wr;
  logic [31:0] word_off;
  logic        in_range;
  logic [ADDR_WIDTH-1:0] idx;

  // Output-process results
  logic        enter_resp;
  logic        mem_we;
  logic        ready_d;
  logic        err_d;
  logic        rd_sel;

  assign in_idle   = (state_q == S_IDLE);
  assign req       = data_rd_en_ma | data_wr_en_ma;
  assign eff_addr  = in_idle ? data_addr       : addr_q;
  assign eff_wdata = in_idle ? data_wr         : wdata_q;
  assign eff_strb  = in_idle ? data_rd_en_ctrl : strb_q;
  assign eff_rd    = in_idle ? data_rd_en_ma   : rd_q;
  assign eff_wr    = in_idle ? data_wr_en_ma   : wr_q;

  // Modular 32-bit subtraction: addresses below BASE_ADDR wrap to a huge
  // offset and fall out of range naturally.
  assign word_off  = (eff_addr - BASE_ADDR) >> 2;
  assign in_range  = ((word_off >> ADDR_WIDTH) == 32'd0);
  assign idx       = word_off[ADDR_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Process 1: state register and request latch
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_idle && req) begin
        addr_q  <= data_addr;
        wdata_q <= data_wr;
        strb_q  <= data_rd_en_ctrl;
        rd_q    <= data_rd_en_ma;
        wr_q    <= data_wr_en_ma;
        cnt_q   <= 4'(WAIT_CYCLES - 1);
      end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: output logic (values captured on the RESP entry edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    enter_resp = (state_d == S_RESP) && (state_q != S_RESP) && !reset;
    // rd & wr together is treated as a write but still reported as an error.
    mem_we     = enter_resp && eff_wr && in_range;
    rd_sel     = enter_resp && eff_rd && !eff_wr && in_range;
    ready_d    = enter_resp;
    err_d      = enter_resp && (!in_range || (eff_rd && eff_wr));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_ready <= 1'b0;
      data_rd    <= '0;
      access_err <= 1'b0;
    end else begin
      data_ready <= ready_d;
      data_rd    <= rd_sel ? mem[idx] : 32'd0;
      access_err <= err_d;
    end
  end

  // NOTE: the storage array has no reset; clearing it would force a flop
  // implementation instead of SRAM, and its contents are undefined until written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && eff_strb[i]) begin
        mem[idx][8*i +: 8] <= eff_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. Three instances with WAIT_CYCLES of
// 1, 0 and 3 share address/data/strobe/reset; each one has its own request
// enables so that only the addressed instance sees a transaction.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [3:0]  data_rd_en_ctrl;

  logic        rd1, wr1, rd0, wr0, rd3, wr3;
  logic        rdy1, rdy0, rdy3;
  logic [31:0] drd1, drd0, drd3;
  logic        err1, err0, err3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .data_rd_en_ma(rd1), .data_wr_en_ma(wr1),
    .data_addr(data_addr), .data_wr(data_wr), .data_rd_en_ctrl(data_rd_en_ctrl),
    .data_ready(rdy1), .data_rd(drd1), .access_err(err1));

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .data_rd_en_ma(rd0), .data_wr_en_ma(wr0),
    .data_addr(data_addr), .data_wr(data_wr), .data_rd_en_ctrl(data_rd_en_ctrl),
    .data_ready(rdy0), .data_rd(drd0), .access_err(err0));

  data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .data_rd_en_ma(rd3), .data_wr_en_ma(wr3),
    .data_addr(data_addr), .data_wr(data_wr), .data_rd_en_ctrl(data_rd_en_ctrl),
    .data_ready(rdy3), .data_rd(drd3), .access_err(err3));

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_en(input int inst, input logic rd, input logic wr);
    case (inst)
      0:       begin rd0 = rd; wr0 = wr; end
      3:       begin rd3 = rd; wr3 = wr; end
      default: begin rd1 = rd; wr1 = wr; end
    endcase
  endtask

  task automatic get_out(input int inst, output logic r, output logic [31:0] d,
                         output logic e);
    case (inst)
      0:       begin r = rdy0; d = drd0; e = err0; end
      3:       begin r = rdy3; d = drd3; e = err3; end
      default: begin r = rdy1; d = drd1; e = err1; end
    endcase
  endtask

  // One complete transaction. Latency is the number of sampled cycles after
  // the accept edge in which data_ready stays low before the pulse.
  task automatic txn(input int inst, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input int exp_lat, input logic chk_data, input logic [31:0] exp_d,
                     input logic exp_err, input string tag);
    logic        r, e;
    logic [31:0] d;
    int          cnt;
    @(negedge clk);
    data_addr       = a;
    data_wr         = wd;
    data_rd_en_ctrl = st;
    set_en(inst, rd, wr);
    @(posedge clk);
    @(negedge clk);
    cnt = 0;
    get_out(inst, r, d, e);
    while (r !== 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
      get_out(inst, r, d, e);
    end
    chk(32'(cnt), 32'(exp_lat), {tag, " latency"});
    if (chk_data) chk(d, exp_d, {tag, " data"});
    chk({31'd0, e}, {31'd0, exp_err}, {tag, " err"});
    set_en(inst, 1'b0, 1'b0);
    @(negedge clk);
    get_out(inst, r, d, e);
    chk({31'd0, r}, 32'd0, {tag, " single pulse"});
  endtask

  initial begin
    logic        r, e;
    logic [31:0] d;

    reset = 1'b1;
    data_addr = '0; data_wr = '0; data_rd_en_ctrl = '0;
    rd1 = 0; wr1 = 0; rd0 = 0; wr0 = 0; rd3 = 0; wr3 = 0;

    // 1: reset state and no spurious pulse after release
    repeat (3) @(negedge clk);
    chk({31'd0, rdy1}, 32'd0, "reset ready");
    chk(drd1, 32'd0, "reset data");
    chk({31'd0, err1}, 32'd0, "reset err");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk({29'd0, rdy0, rdy1, rdy3}, 32'd0, "idle no pulse");
    end

    // 2: full-word store/load, WAIT=1
    txn(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, 0, 0, "st 0x10");
    txn(1, 1, 0, 32'h10, 32'h0, 4'hF, 1, 1, 32'hDEADBEEF, 0, "ld 0x10");
    txn(1, 1, 0, 32'h13, 32'h0, 4'h0, 1, 1, 32'hDEADBEEF, 0, "ld 0x13 low bits ignored");

    // 3: byte-lane strobes
    txn(1, 0, 1, 32'h20, 32'h11223344, 4'hF, 1, 0, 0, 0, "st 0x20 init");
    txn(1, 0, 1, 32'h20, 32'h000000AA, 4'h1, 1, 0, 0, 0, "st 0x20 lane0");
    txn(1, 0, 1, 32'h20, 32'h0000BB00, 4'h2, 1, 0, 0, 0, "st 0x20 lane1");
    txn(1, 1, 0, 32'h20, 32'h0, 4'hF, 1, 1, 32'h1122BBAA, 0, "ld 0x20 merged");
    txn(1, 0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 1, 0, 0, 0, "st strb0");
    txn(1, 1, 0, 32'h10, 32'h0, 4'hF, 1, 1, 32'hDEADBEEF, 0, "ld after strb0");

    // 4: WAIT=0 and WAIT=3 latency sweeps
    txn(0, 0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, "w0 st 0x0");
    txn(0, 1, 0, 32'h0, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D, 0, "w0 ld 0x0");
    txn(3, 0, 1, 32'h0, 32'h0BADF00D, 4'hF, 3, 0, 0, 0, "w3 st 0x0");
    txn(3, 1, 0, 32'h0, 32'h0, 4'hF, 3, 1, 32'h0BADF00D, 0, "w3 ld 0x0");

    // 5: range boundary and out-of-range accesses
    txn(1, 0, 1, 32'h0, 32'h01020304, 4'hF, 1, 0, 0, 0, "st 0x0");
    txn(1, 0, 1, 32'hFFC, 32'h5A5A5A5A, 4'hF, 1, 0, 0, 0, "st last word");
    txn(1, 1, 0, 32'hFFC, 32'h0, 4'hF, 1, 1, 32'h5A5A5A5A, 0, "ld last word");
    txn(1, 1, 0, 32'h1000, 32'h0, 4'hF, 1, 1, 32'h0, 1, "ld out of range");
    txn(1, 0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 1, "st out of range");
    txn(1, 1, 0, 32'h0, 32'h0, 4'hF, 1, 1, 32'h01020304, 0, "ld 0x0 intact");

    // 6: reset during WAIT abandons the store
    txn(1, 0, 1, 32'h30, 32'hA5A5A5A5, 4'hF, 1, 0, 0, 0, "st 0x30 old");
    @(negedge clk);
    data_addr = 32'h30; data_wr = 32'h12345678; data_rd_en_ctrl = 4'hF;
    wr1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({31'd0, rdy1}, 32'd0, "in WAIT ready low");
    reset = 1'b1;
    wr1   = 1'b0;
    #1;
    get_out(1, r, d, e);
    chk({30'd0, r, e}, 32'd0, "mid-txn reset outputs");
    chk(d, 32'd0, "mid-txn reset data");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk({31'd0, rdy1}, 32'd0, "after reset no pulse");
    txn(1, 1, 0, 32'h30, 32'h0, 4'hF, 1, 1, 32'hA5A5A5A5, 0, "ld 0x30 not committed");

    // rd & wr together: write performed, error flagged
    txn(1, 1, 1, 32'h40, 32'h0F0F0F0F, 4'hF, 1, 0, 0, 1, "rd&wr");
    txn(1, 1, 0, 32'h40, 32'h0, 4'hF, 1, 1, 32'h0F0F0F0F, 0, "ld after rd&wr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
